// File: rtl/ixc_assign_pkg.sv
// Shared constants and helpers for the registered assign pipeline.
// Imported by the stage slice and by the top level.
package ixc_assign_pkg;

   localparam int IXC_ASSIGN_DEF_W      = 106;
   localparam int IXC_ASSIGN_MAX_STAGES = 8;

   // Smallest counter width that can hold 0..stages, never below one bit.
   function automatic int ixc_assign_cnt_w(input int stages);
      return (stages < 1) ? 1 : $clog2(stages + 1);
   endfunction

endpackage

// File: rtl/ixc_assign_stage.sv
// One W-bit valid/ready register slice with synchronous flush and async reset.
// Ready is combinational from downstream, so a full chain still streams at one word per cycle.
module ixc_assign_stage
   import ixc_assign_pkg::*;
#(
   parameter int W = IXC_ASSIGN_DEF_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;
   logic         accept;

   assign accept = ~valid_q | out_ready;

   // Data only moves on a real load, so held words stay stable under backpressure and flush.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d = in_valid;
         if (in_valid) begin
            data_d = in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign in_ready  = accept;
   assign out_data  = data_q;
   assign out_valid = valid_q;

endmodule

// File: rtl/ixc_assign_pipe.sv
// Registered replacement for a flat cross-partition assign: STAGES valid/ready slices,
// a per-bit force overlay on L, synchronous flush and an occupancy count.
module ixc_assign_pipe
   import ixc_assign_pkg::*;
#(
   parameter int W      = IXC_ASSIGN_DEF_W,
   parameter int STAGES = 2,
   parameter int CNT_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [W-1:0]     R,
   input  logic             R_valid,
   output logic             R_ready,
   output logic [W-1:0]     L,
   output logic             L_valid,
   input  logic             L_ready,
   input  logic             flush,
   input  logic [W-1:0]     force_en,
   input  logic [W-1:0]     force_val,
   output logic [CNT_W-1:0] occ
);

   logic [W-1:0] core_data;

   if (STAGES == 0) begin : g_pass
      assign core_data = R;
      assign L_valid   = R_valid;
      assign R_ready   = L_ready & ~flush;
      assign occ       = '0;
   end else begin : g_pipe
      logic [W-1:0]     d [0:STAGES];
      logic [STAGES:0]  v;
      logic [STAGES:0]  rdy;
      logic [CNT_W-1:0] occ_cnt;

      assign d[0]        = R;
      assign v[0]        = R_valid;
      assign rdy[STAGES] = L_ready;

      for (genvar k = 0; k < STAGES; k++) begin : g_stage
         ixc_assign_stage #(.W(W)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_data   (d[k]),
            .in_valid  (v[k]),
            .in_ready  (rdy[k]),
            .out_data  (d[k+1]),
            .out_valid (v[k+1]),
            .out_ready (rdy[k+1])
         );
      end

      // Occupancy is derived from the slice valids rather than kept as a separate counter.
      always_comb begin
         occ_cnt = '0;
         for (int k = 1; k <= STAGES; k++) begin
            occ_cnt = occ_cnt + CNT_W'(v[k]);
         end
      end

      assign core_data = d[STAGES];
      assign L_valid   = v[STAGES];
      assign R_ready   = rdy[0] & ~flush;
      assign occ       = occ_cnt;
   end

   assign L = (force_en & force_val) | (~force_en & core_data);

endmodule

// File: tb/tb_ixc_assign_pipe.sv
// Directed self-checking bench for ixc_assign_pipe: a 2-stage instance and a
// pass-through (STAGES=0) instance, hand-computed expectations throughout.
module tb_ixc_assign_pipe;

   localparam int W = 106;

   logic         clk;
   logic         rst_n;

   logic [W-1:0] R, L, force_en, force_val;
   logic         R_valid, R_ready, L_valid, L_ready, flush;
   logic [3:0]   occ;

   logic [W-1:0] p_R, p_L, p_force_en, p_force_val;
   logic         p_R_valid, p_R_ready, p_L_valid, p_L_ready, p_flush;
   logic [3:0]   p_occ;

   int checks;
   int errors;

   logic [W-1:0] force_mask;

   ixc_assign_pipe #(.W(W), .STAGES(2), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .R         (R),
      .R_valid   (R_valid),
      .R_ready   (R_ready),
      .L         (L),
      .L_valid   (L_valid),
      .L_ready   (L_ready),
      .flush     (flush),
      .force_en  (force_en),
      .force_val (force_val),
      .occ       (occ)
   );

   ixc_assign_pipe #(.W(W), .STAGES(0), .CNT_W(4)) dut_pass (
      .clk       (clk),
      .rst_n     (rst_n),
      .R         (p_R),
      .R_valid   (p_R_valid),
      .R_ready   (p_R_ready),
      .L         (p_L),
      .L_valid   (p_L_valid),
      .L_ready   (p_L_ready),
      .flush     (p_flush),
      .force_en  (p_force_en),
      .force_val (p_force_val),
      .occ       (p_occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      force_mask  = (106'd1 << 105) | (106'd1 << 5);
      rst_n       = 1'b0;
      R           = '0;
      R_valid     = 1'b0;
      L_ready     = 1'b1;
      flush       = 1'b0;
      force_en    = '0;
      force_val   = '0;
      p_R         = '0;
      p_R_valid   = 1'b0;
      p_L_ready   = 1'b0;
      p_flush     = 1'b0;
      p_force_en  = '0;
      p_force_val = '0;

      // Reset state, including the overlay acting on zeroed stage data
      #2;
      checkOutput("rst_L_valid", 128'(L_valid), 128'(0));
      checkOutput("rst_occ", 128'(occ), 128'(0));
      checkOutput("rst_R_ready", 128'(R_ready), 128'(1));
      force_en  = force_mask;
      force_val = '1;
      #1;
      checkOutput("rst_L_forced", 128'(L), 128'(force_mask));
      force_en  = '0;
      force_val = '0;
      #1;
      checkOutput("rst_L_zero", 128'(L), 128'(0));
      tick();
      rst_n = 1'b1;
      tick();

      // Streaming, L_ready held high
      R = 106'h1; R_valid = 1'b1; #1;
      checkOutput("str_R_ready", 128'(R_ready), 128'(1));
      tick(); R = 106'h2; #1;
      checkOutput("str_c1_L_valid", 128'(L_valid), 128'(0));
      checkOutput("str_c1_occ", 128'(occ), 128'(1));
      tick(); R = 106'h3; #1;
      checkOutput("str_c2_L_valid", 128'(L_valid), 128'(1));
      checkOutput("str_c2_L", 128'(L), 128'(1));
      checkOutput("str_c2_occ", 128'(occ), 128'(2));
      tick(); R_valid = 1'b0; #1;
      checkOutput("str_c3_L", 128'(L), 128'(2));
      checkOutput("str_c3_occ", 128'(occ), 128'(2));
      tick(); #1;
      checkOutput("str_c4_L", 128'(L), 128'(3));
      checkOutput("str_c4_occ", 128'(occ), 128'(1));
      tick(); #1;
      checkOutput("str_c5_L_valid", 128'(L_valid), 128'(0));
      checkOutput("str_c5_occ", 128'(occ), 128'(0));

      // Backpressure: four words offered with the sink stalled
      L_ready = 1'b0; R = 106'h11; R_valid = 1'b1; #1;
      checkOutput("bp_ready0", 128'(R_ready), 128'(1));
      tick(); R = 106'h12; #1;
      checkOutput("bp_ready1", 128'(R_ready), 128'(1));
      tick(); R = 106'h13; #1;
      checkOutput("bp_ready_full", 128'(R_ready), 128'(0));
      checkOutput("bp_occ_full", 128'(occ), 128'(2));
      checkOutput("bp_L_head", 128'(L), 128'(106'h11));
      tick(); #1;
      checkOutput("bp_L_stable", 128'(L), 128'(106'h11));
      checkOutput("bp_L_valid_stable", 128'(L_valid), 128'(1));
      checkOutput("bp_ready_stall", 128'(R_ready), 128'(0));
      L_ready = 1'b1; #1;
      checkOutput("bp_ready_release", 128'(R_ready), 128'(1));
      tick(); R = 106'h14; #1;
      checkOutput("bp_drain_12", 128'(L), 128'(106'h12));
      tick(); R_valid = 1'b0; #1;
      checkOutput("bp_drain_13", 128'(L), 128'(106'h13));
      checkOutput("bp_drain_occ2", 128'(occ), 128'(2));
      tick(); #1;
      checkOutput("bp_drain_14", 128'(L), 128'(106'h14));
      checkOutput("bp_drain_occ1", 128'(occ), 128'(1));
      tick(); #1;
      checkOutput("bp_empty_valid", 128'(L_valid), 128'(0));
      checkOutput("bp_empty_occ", 128'(occ), 128'(0));

      // Flush with a simultaneous R_valid that must be dropped
      L_ready = 1'b0; R = 106'h21; R_valid = 1'b1;
      tick(); R = 106'h22;
      tick(); R = 106'hAA; flush = 1'b1; #1;
      checkOutput("fl_occ_before", 128'(occ), 128'(2));
      checkOutput("fl_R_ready", 128'(R_ready), 128'(0));
      tick(); flush = 1'b0; R_valid = 1'b0; #1;
      checkOutput("fl_L_valid", 128'(L_valid), 128'(0));
      checkOutput("fl_occ", 128'(occ), 128'(0));
      checkOutput("fl_no_AA", 128'(L == 106'hAA), 128'(0));
      L_ready = 1'b1;
      tick(); #1;
      checkOutput("fl_no_AA_later", 128'(L == 106'hAA), 128'(0));
      checkOutput("fl_still_empty", 128'(L_valid), 128'(0));

      // Force overlay over a stream of zeros
      force_en = force_mask; force_val = '1; R = '0; R_valid = 1'b1;
      tick();
      tick(); R_valid = 1'b0; #1;
      checkOutput("frc_L_valid", 128'(L_valid), 128'(1));
      checkOutput("frc_L", 128'(L), 128'(force_mask));
      force_en = '0; #1;
      checkOutput("frc_release_L", 128'(L), 128'(0));
      tick();
      tick(); #1;
      checkOutput("frc_occ_end", 128'(occ), 128'(0));

      // Asynchronous reset between edges with two words held
      L_ready = 1'b0; R = 106'h31; R_valid = 1'b1;
      tick(); R = 106'h32;
      tick(); R_valid = 1'b0; #1;
      checkOutput("ar_occ_before", 128'(occ), 128'(2));
      #1; rst_n = 1'b0; #1;
      checkOutput("ar_L_valid", 128'(L_valid), 128'(0));
      checkOutput("ar_occ", 128'(occ), 128'(0));
      checkOutput("ar_R_ready", 128'(R_ready), 128'(1));
      @(negedge clk); rst_n = 1'b1;
      tick(); L_ready = 1'b1; R = 106'h55; R_valid = 1'b1;
      tick(); R_valid = 1'b0; #1;
      checkOutput("ar_lat1", 128'(L_valid), 128'(0));
      tick(); #1;
      checkOutput("ar_lat2_valid", 128'(L_valid), 128'(1));
      checkOutput("ar_lat2_L", 128'(L), 128'(106'h55));

      // Pass-through instance: everything combinational in the same cycle
      p_R = 106'h2_0000_0000_0000_0000_0000_1234; p_R_valid = 1'b1; p_L_ready = 1'b0; #1;
      checkOutput("p_L", 128'(p_L), 128'(106'h2_0000_0000_0000_0000_0000_1234));
      checkOutput("p_L_valid_1", 128'(p_L_valid), 128'(1));
      checkOutput("p_R_ready_0", 128'(p_R_ready), 128'(0));
      p_R_valid = 1'b0; p_L_ready = 1'b1; #1;
      checkOutput("p_L_valid_0", 128'(p_L_valid), 128'(0));
      checkOutput("p_R_ready_1", 128'(p_R_ready), 128'(1));
      p_flush = 1'b1; #1;
      checkOutput("p_R_ready_flush", 128'(p_R_ready), 128'(0));
      p_flush = 1'b0; p_force_en = 106'hF; p_force_val = '0; #1;
      checkOutput("p_L_forced", 128'(p_L), 128'(106'h2_0000_0000_0000_0000_0000_1230));
      checkOutput("p_occ", 128'(p_occ), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
